// File: rtl/junction_phase_scheduler.sv
// Round-robin green-phase scheduler for a four-approach junction with
// min/max green, yellow and all-red clearance intervals; outputs are registered.
module junction_phase_scheduler #(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int TW          = 8
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] req,
  output logic [7:0] lights,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       phase_start
);

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST   = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_TIME - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    ptr;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       own_req;
  logic       others;
  logic       min_done;
  logic       max_hit;

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    winner = ptr;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign own_req  = req[grant_id];
  assign others   = |(req & ~(4'b0001 << grant_id));
  assign min_done = (timer >= MIN_LAST);
  assign max_hit  = (timer >= MAX_LAST);

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= ALLRED;
      timer       <= '0;
      ptr         <= 2'd3;
      grant_id    <= 2'd0;
      lights      <= 8'h00;
      grant_valid <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      phase_start <= 1'b0;
      case (state)
        ALLRED: begin
          if (timer >= AR_LAST) begin
            // Timer rests at its last value until someone asks for green.
            if (found) begin
              state       <= GREEN;
              timer       <= '0;
              ptr         <= winner;
              grant_id    <= winner;
              lights      <= 8'h02 << {winner, 1'b0};
              grant_valid <= 1'b1;
              phase_start <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GREEN: begin
          if (min_done && (!own_req || (max_hit && others))) begin
            state  <= YELLOW;
            timer  <= '0;
            lights <= 8'h01 << {grant_id, 1'b0};
          end else if (!max_hit) begin
            timer <= timer + 1'b1;
          end
        end
        YELLOW: begin
          if (timer >= Y_LAST) begin
            state       <= ALLRED;
            timer       <= '0;
            lights      <= 8'h00;
            grant_valid <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state       <= ALLRED;
          timer       <= '0;
          lights      <= 8'h00;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
